// File: rtl/layer_seq_pkg.sv
// layer_seq_pkg: shared types and encodings for the layer sequencer.
//   layer_type_e  - descriptor layer type as it arrives on desc_type
//   CS_*          - comp_sel codes understood by buffer_pea_mux
//   AB_*          - aybz_azby ping-pong mode codes
//   seq_state_e   - sequencer FSM states
//   desc_hdr_t    - descriptor control fields (the cfg word is appended
//                   by the sequencer because its width is a parameter)
package layer_seq_pkg;

    typedef enum logic [1:0] {
        LT_INVALID = 2'b00,
        LT_CONV    = 2'b01,
        LT_DENSE   = 2'b10,
        LT_POOL    = 2'b11
    } layer_type_e;

    localparam logic [2:0] CS_IDLE  = 3'b000;
    localparam logic [2:0] CS_CONV  = 3'b001;
    localparam logic [2:0] CS_DENSE = 3'b010;
    localparam logic [2:0] CS_POOL  = 3'b011;

    localparam logic [1:0] AB_AYBZ = 2'b01;
    localparam logic [1:0] AB_AZBY = 2'b00;
    localparam logic [1:0] AB_AYAZ = 2'b11;
    localparam logic [1:0] AB_BYBZ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_START,
        S_RUN,
        S_NEXT
    } seq_state_e;

    typedef struct packed {
        layer_type_e dtype;
        logic        last;
    } desc_hdr_t;

    function automatic logic [2:0] type_to_sel(input layer_type_e t);
        case (t)
            LT_CONV:  return CS_CONV;
            LT_DENSE: return CS_DENSE;
            LT_POOL:  return CS_POOL;
            default:  return CS_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/layer_desc_fifo.sv
// layer_desc_fifo: synchronous FIFO holding queued layer descriptors.
//   clk, rst          - clock, synchronous active-high reset (pointers/count)
//   push, wr_data     - write request; ignored while full
//   pop               - read request; ignored while empty
//   rd_data           - head entry (valid while !empty)
//   full, empty, count- occupancy, all derived from the registered count
module layer_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not open a slot until the next cycle.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs queued layer descriptors one at a time, steering
// buffer_pea_mux and pulsing the matching engine start.
//   desc_valid/desc_ready/desc_type/desc_cfg/desc_last - descriptor input
//   start_conv/start_dense/start_pool - one-cycle engine starts
//   done_conv/done_dense/done_pool    - engine completion pulses
//   cfg_out    - current layer configuration
//   comp_sel   - mux computation select
//   aybz_azby  - mux ping-pong mode {is_dense, ping}
//   busy, net_done, err, layer_cnt    - status
// All outputs are registered.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CFG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             desc_valid,
    output logic             desc_ready,
    input  logic [1:0]       desc_type,
    input  logic [CFG_W-1:0] desc_cfg,
    input  logic             desc_last,
    output logic             start_conv,
    output logic             start_dense,
    output logic             start_pool,
    output logic [CFG_W-1:0] cfg_out,
    input  logic             done_conv,
    input  logic             done_dense,
    input  logic             done_pool,
    output logic [2:0]       comp_sel,
    output logic [1:0]       aybz_azby,
    output logic             busy,
    output logic             net_done,
    output logic             err,
    output logic [CNT_W-1:0] layer_cnt
);
    typedef struct packed {
        desc_hdr_t        hdr;
        logic [CFG_W-1:0] cfg;
    } desc_t;

    desc_t                 wr_desc;
    desc_t                 head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  pop;

    seq_state_e  state_q, state_d;
    layer_type_e cur_type;
    logic        cur_last;
    logic        ping_q, ping_d;
    logic        bad_type;
    logic        active;
    logic        done_sel;
    logic        done_stray;

    assign wr_desc.hdr.dtype = layer_type_e'(desc_type);
    assign wr_desc.hdr.last  = desc_last;
    assign wr_desc.cfg       = desc_cfg;
    assign desc_ready        = !fifo_full;

    layer_desc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(desc_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (desc_valid),
        .wr_data (wr_desc),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assert property (@(posedge clk) disable iff (rst) fifo_empty == (fifo_count == '0));

    // An engine counts as selected only while its layer is in flight; any
    // other done pulse is stray.
    assign active     = (state_q == S_SETUP) || (state_q == S_START) || (state_q == S_RUN);
    assign done_sel   = (cur_type == LT_CONV  && done_conv)  ||
                        (cur_type == LT_DENSE && done_dense) ||
                        (cur_type == LT_POOL  && done_pool);
    assign done_stray = (done_conv  && !(active && cur_type == LT_CONV))  ||
                        (done_dense && !(active && cur_type == LT_DENSE)) ||
                        (done_pool  && !(active && cur_type == LT_POOL));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        bad_type = 1'b0;
        ping_d   = ping_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (head.hdr.dtype == LT_INVALID) bad_type = 1'b1;
                    else                              state_d  = S_SETUP;
                end
            end
            S_SETUP: state_d = S_START;
            // A done landing in the START cycle itself is honoured.
            S_START, S_RUN: state_d = done_sel ? S_NEXT : S_RUN;
            S_NEXT: begin
                state_d = S_IDLE;
                ping_d  = cur_last ? 1'b1 : !ping_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_type    <= LT_INVALID;
            cur_last    <= 1'b0;
            cfg_out     <= '0;
            ping_q      <= 1'b1;
            comp_sel    <= CS_IDLE;
            aybz_azby   <= AB_AYBZ;
            start_conv  <= 1'b0;
            start_dense <= 1'b0;
            start_pool  <= 1'b0;
            busy        <= 1'b0;
            net_done    <= 1'b0;
            err         <= 1'b0;
            layer_cnt   <= '0;
        end else begin
            ping_q <= ping_d;
            if (state_d == S_SETUP) begin
                cur_type  <= head.hdr.dtype;
                cur_last  <= head.hdr.last;
                cfg_out   <= head.cfg;
                comp_sel  <= type_to_sel(head.hdr.dtype);
                aybz_azby <= {head.hdr.dtype == LT_DENSE, ping_q};
            end else if (state_d == S_IDLE || state_d == S_NEXT) begin
                comp_sel  <= CS_IDLE;
                aybz_azby <= {1'b0, ping_d};
            end
            start_conv  <= (state_q == S_SETUP) && (cur_type == LT_CONV);
            start_dense <= (state_q == S_SETUP) && (cur_type == LT_DENSE);
            start_pool  <= (state_q == S_SETUP) && (cur_type == LT_POOL);
            busy        <= (state_d == S_SETUP) || (state_d == S_START) || (state_d == S_RUN);
            net_done    <= (state_q == S_NEXT) && cur_last;
            err         <= err || bad_type || done_stray;
            // Count clears the cycle after net_done so it reads the total once.
            if (state_q == S_NEXT) layer_cnt <= layer_cnt + CNT_W'(1);
            else if (net_done)     layer_cnt <= '0;
        end
    end

endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Layer-level scheduler that sits upstream of `buffer_pea_mux` and the conv/dense/pool engine controllers. It accepts a stream of layer descriptors into a small FIFO and, one layer at a time, drives the mux's computation select and ping-pong mode. It starts the matching engine with a one-cycle pulse and waits for that engine's done. Between layers it toggles which buffer drives the PE array, so each layer's output buffer becomes the next layer's input buffer.

## Interface
Parameters:
- `DEPTH`, 4: descriptor FIFO entries (power of two, ≥2).
- `CFG_W`, 32: opaque per-layer configuration word forwarded to the engine.
- `CNT_W`, 8: width of the completed-layer counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `desc_valid` in 1: descriptor offered.
- `desc_ready` out 1: FIFO not full; a descriptor is accepted when `desc_valid && desc_ready`.
- `desc_type` in 2: 01 conv, 10 dense, 11 pool, 00 invalid.
- `desc_cfg` in CFG_W: layer configuration word.
- `desc_last` in 1: final layer of the network.
- `start_conv`, `start_dense`, `start_pool` out 1 each: one-cycle engine start pulses.
- `cfg_out` out CFG_W: configuration of the current layer, held stable from SETUP through RUN.
- `done_conv`, `done_dense`, `done_pool` in 1 each: engine completion pulses.
- `comp_sel` out 3: to the mux; 000 idle, 001 conv, 010 dense, 011 pool.
- `aybz_azby` out 2: to the mux; the top level fans it to the conv, dense and pool inputs.
- `busy` out 1: a layer is in flight (state SETUP, START or RUN).
- `net_done` out 1: one-cycle pulse after the `desc_last` layer completes.
- `err` out 1: sticky error flag; cleared only by `rst`.
- `layer_cnt` out CNT_W: layers completed since reset or since the last `net_done`; wraps modulo 2^CNT_W.

## Operation
- **FSM states:** IDLE, SETUP, START, RUN, NEXT.
- **IDLE:** `comp_sel`=000. If the FIFO is non-empty, pop the head into the current-layer register.
  - Invalid type (00): set `err`, drop the descriptor, stay in IDLE. The ping bit is unchanged.
  - Otherwise go to SETUP.
- **SETUP (1 cycle):** drive `comp_sel` for the current layer type.
  - Drive `aybz_azby = {is_dense, ping}`.
  - This gives the mux one settled cycle before the engine starts.
- **START (1 cycle):** assert exactly one `start_*`, matching the current type, then go to RUN.
- **RUN:** hold `comp_sel`, `aybz_azby` and `cfg_out`. Wait for the `done_*` of the selected engine.
  - A `done_*` from a non-selected engine in any state sets `err` and is otherwise ignored.
- **NEXT (1 cycle):**
  - Toggle `ping`.
  - Increment `layer_cnt`.
  - If the current layer is last: pulse `net_done`, set `ping`=1, clear `layer_cnt` on the following cycle, then go to IDLE.
  - If not last: go to IDLE. The next descriptor is popped there and `ping` is retained.
- **ping:** resets to 1, meaning BUF1 drives (modes 01 and 11). `ping`=0 means BUF2 drives (modes 00 and 10).
- **IDLE output:** `aybz_azby` = {0, ping}.
- **FIFO:**
  - Push and pop in the same cycle are both honoured when the FIFO is non-empty and not full.
  - `desc_ready` depends only on the count. It is low when the FIFO is full, even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
- **Reset values:** state IDLE, FIFO empty, `desc_ready`=1, all `start_*`=0, `cfg_out`=0, `comp_sel`=000, `aybz_azby`=01, `busy`=0, `net_done`=0, `err`=0, `layer_cnt`=0, `ping`=1.
- **Reset mid-layer:** abort immediately. All outputs return to reset values the next cycle and FIFO contents are discarded. Late `done_*` pulses arriving in IDLE set `err`, so the bench must hold the engines in reset alongside.

## Timing
- **Descriptor to start:** a descriptor accepted at edge T into an empty FIFO with the FSM in IDLE is popped at T+1. SETUP is at T+2 and `start_*` is high during T+3.
- **Between layers:** `done_*` high at cycle D puts NEXT at D+1 and IDLE at D+2, with the pop in that cycle. SETUP is at D+3 and the next start at D+4, assuming a descriptor is waiting. Minimum gap from done to start is 4 cycles.
- **Done during START:** a matching `done_*` in the START cycle is accepted; the FSM goes straight to NEXT.
- **Registered outputs:** all outputs are registered and there are no combinational paths from inputs to outputs.
- **Throughput:** one layer in flight at a time.

## Structure
- **Package `layer_seq_pkg`:**
  - `layer_type_e` (INVALID, CONV, DENSE, POOL).
  - `comp_sel` constants (IDLE, CONV, DENSE, POOL).
  - `aybz_azby` constants (AYBZ=01, AZBY=00, AYAZ=11, BYBZ=10).
  - FSM state enum.
  - Descriptor struct {type, last, cfg}.
- **Sub-module `layer_desc_fifo`:** a synchronous FIFO parameterised by DEPTH and width, with full/empty/count outputs.

## Test plan
- **Single conv, last=1:** `comp_sel`=001 and `aybz_azby`=01 at T+2; `start_conv` high only at T+3. `done_conv` then gives `net_done` 2 cycles later, `layer_cnt` shows 1 then 0, and `ping` returns to 1.
- **Conv, pool, dense (last) queued back-to-back:** `aybz_azby` sequence is 01, 00, 11. `comp_sel` sequence is 001, 011, 010. Each start comes 4 cycles after the previous done.
- **Push 5 descriptors with DEPTH=4 while the FSM is in RUN:** `desc_ready` drops after the 4th. The 5th is accepted the cycle after the next pop, and all five execute in order.
- **desc_type=00 between two conv layers:** `err`=1 and the invalid entry is dropped. The second conv uses `aybz_azby`=00 because the toggle is not disturbed.
- **`done_pool` injected while a dense layer runs:** `err`=1, the FSM stays in RUN, and the later `done_dense` completes the layer normally.
- **`rst` asserted in RUN with 2 descriptors queued:** all outputs take their reset values the next cycle, `desc_ready`=1, and no start pulse follows.
